// File: rtl/param_display.sv
// param_display: sequential double-dabble conversion of fx/param/value onto six active-low 7-segment digits
module param_display #(
  parameter int FX_COUNT      = 16,
  parameter int PARAM_COUNT   = 8,
  parameter int PARAM_W       = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(FX_COUNT)-1:0]    fx_sel,
  input  logic [$clog2(PARAM_COUNT)-1:0] param_sel,
  input  logic [PARAM_W-1:0]             current_value,
  output logic [6:0]                     hex5,
  output logic [6:0]                     hex4,
  output logic [6:0]                     hex3,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex0,
  output logic                           busy,
  output logic                           update
);
  localparam int FW = $clog2(FX_COUNT);
  localparam int SW = $clog2(PARAM_COUNT);
  localparam int CW = $clog2(PARAM_W + 1);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2;
  localparam logic [6:0] BLANK = 7'h7f;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = BLANK;
    endcase
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    adj = n >= 4'd5 ? n + 4'd3 : n;
  endfunction

  logic [1:0]         state;
  logic [FW-1:0]      sh_fx;
  logic [SW-1:0]      sh_param;
  logic [PARAM_W-1:0] sh_val;
  logic               force_conv;
  logic [11:0]        bcd, bcd_adj;
  logic [PARAM_W-1:0] src;
  logic [CW-1:0]      cnt;
  logic [3:0]         fx4, fx_ones, prm4;
  logic               fx_tens, changed, blank_h, blank_t;

  always_comb begin
    bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
    fx4     = 4'(sh_fx);
    prm4    = 4'(sh_param);
    fx_tens = fx4 >= 4'd10;
    fx_ones = fx_tens ? fx4 - 4'd10 : fx4;
    changed = force_conv || ({fx_sel, param_sel, current_value} != {sh_fx, sh_param, sh_val});
    blank_h = BLANK_LEADING != 0 && bcd[11:8] == 4'd0;
    blank_t = blank_h && bcd[7:4] == 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh_fx      <= '0;
      sh_param   <= '0;
      sh_val     <= '0;
      force_conv <= 1'b1;
      bcd        <= '0;
      src        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      update     <= 1'b0;
      {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{BLANK}};
    end else begin
      update <= 1'b0;
      if (state == IDLE && changed) begin
        sh_fx      <= fx_sel;
        sh_param   <= param_sel;
        sh_val     <= current_value;
        force_conv <= 1'b0;
        bcd        <= '0;
        src        <= current_value;
        cnt        <= CW'(PARAM_W);
        busy       <= 1'b1;
        state      <= CONV;
      end else if (state == CONV) begin
        {bcd, src} <= {bcd_adj[10:0], src, 1'b0};
        cnt        <= cnt - CW'(1);
        state      <= cnt == CW'(1) ? DONE : CONV;
      end else if (state == DONE) begin
        hex5   <= (BLANK_LEADING != 0 && !fx_tens) ? BLANK : seg({3'd0, fx_tens});
        hex4   <= seg(fx_ones);
        hex3   <= seg(prm4);
        hex2   <= blank_h ? BLANK : seg(bcd[11:8]);
        hex1   <= blank_t ? BLANK : seg(bcd[7:4]);
        hex0   <= seg(bcd[3:0]);
        update <= 1'b1;
        busy   <= 1'b0;
        state  <= IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
